line_buf_pp: RTL and testbench
==============================

Name: line_buf_pp

Overview:
- Parametrised ping-pong scanline buffer for the sprite pipeline.
- The sprite engine draws the next line into the write bank with a read-modify-write priority check. At the same time, the video scan reads the display bank, and each read clears that location.
- Banks swap on a line strobe.
- A power-up sweep clears both banks, and the block flags sprite-over-sprite collisions. It replaces fixed 1024x11 line buffers in the sprite renderer.

Parameters:
- AW, 9, address width; each bank holds 2**AW pixels.
- DW, 11, pixel word width.
- TW, 4, width of the transparency field, DW[TW-1:0]; a value of 0 means transparent.
- PRIO, 1, write mode. 1 = first opaque writer wins (write only over transparent). 0 = unconditional overwrite.
- CLR_VAL, 0, value written on read-clear and during the init sweep. Its low TW bits must be 0.

Ports:
- clk, in, 1, single clock for both sides.
- rst_n, in, 1, asynchronous active-low reset.
- swap, in, 1, one-cycle pulse at line start; exchanges the write and display banks.
- wr_en, in, 1, pixel write request.
- wr_adr, in, AW, pixel x position in the write bank.
- wr_dat, in, DW, pixel value.
- rd_en, in, 1, display read request.
- rd_adr, in, AW, display x position.
- rd_dat, out, DW, display pixel; valid 1 cycle after rd_en.
- rd_vld, out, 1, rd_en delayed 1 cycle.
- bank, out, 1, index of the current write bank; the display bank is ~bank.
- coll, out, 1, one-cycle pulse when an opaque write hits an opaque pixel.
- init_busy, out, 1, high during the post-reset clear sweep.

Behaviour:
- Storage:
  - Two banks of 2**AW x DW. Each bank has one read port and one write port, muxed by bank.
  - Memory is not reset.
- Reset values (async assert): bank=0, rd_dat=CLR_VAL, rd_vld=0, coll=0, init_busy=1, init counter=0, write pipeline empty.
- Init state machine, INIT -> RUN:
  - INIT: write CLR_VAL to address cnt in both banks each cycle; cnt increments.
  - After cnt reaches 2**AW-1, go to RUN on the next cycle, with init_busy=0 on that cycle. The sweep lasts 2**AW cycles.
  - During INIT:
    - wr_en and swap are ignored.
    - rd_en still produces rd_vld, but rd_dat=CLR_VAL.
  - Reasserting rst_n low mid-sweep restarts the sweep from 0.
- Swap (RUN only): bank toggles at the clock edge where swap=1. Writes and reads presented on that same edge use the pre-toggle bank.
- Write pipeline (RUN):
  - Stage 0: capture wr_adr, wr_dat and the bank value. The bank is latched per write, so an in-flight write completes into its original bank across a swap.
  - Stage 1: read the existing pixel.
  - Stage 2: decide and write.
    - PRIO=1: write only if existing[TW-1:0]==0 and wr_dat[TW-1:0]!=0.
    - PRIO=0: write if wr_dat[TW-1:0]!=0.
    - Transparent input pixels are never written.
  - Collision: coll=1 in the stage-2 cycle when the existing pixel and wr_dat are both opaque. This applies in both PRIO modes.
  - Throughput: 1 write per cycle, no stall.
  - Hazard: if a stage-1 address and bank match the stage-2 write in progress, forward the stage-2 data. Back-to-back writes to the same x must behave as sequential.
- Read/clear (RUN):
  - On rd_en, register core[~bank][rd_adr] into rd_dat, with 1-cycle latency, and write CLR_VAL to that location in the same cycle.
  - Without rd_en, rd_dat holds its value.
  - Read and clear use the display bank latched at the request edge.
- Simultaneous events:
  - A write and a read never target the same bank except when a straggling pipeline write lands in the bank just swapped to display. In that case the pipeline write wins and the read returns the pre-write value. This is acceptable because the renderer finishes the line before swap.
  - Address wrap: addresses are modulo 2**AW with no bounds error.

Test Plan:
- Reset, then idle: init_busy stays high exactly 512 cycles (AW=9). After swap, reading x=0..511 returns 0x000 everywhere, including locations pre-loaded with garbage before reset.
- PRIO=1: write x=10 with 0x123, then x=10 with 0x456, then swap and read x=10. rd_dat=0x123 one cycle later; coll pulses once. A second read of x=10 returns 0x000 (cleared).
- Transparency: write x=5 with 0x7F0 (low nibble 0), swap, read x=5 -> 0x000. No coll.
- Back-to-back writes, same address, PRIO=0: 0x101 then 0x202 on consecutive cycles, swap, read -> 0x202. Same with PRIO=1 -> 0x101 with coll=1; this checks forwarding.
- Swap mid-pipeline: wr_en x=20 with 0x0A1 on the swap edge. The pixel appears in the old write bank, now the display bank; bank toggles from 0 to 1.
- Async reset: assert rst_n low mid-read. rd_vld=0, rd_dat=CLR_VAL, bank=0 and init_busy=1 immediately, without waiting for a clock; after release the sweep restarts from 0.

Source files
------------

// File: rtl/line_buf_pp.sv
// Ping-pong scanline buffer: sprite side draws into the write bank via a
// 3-stage priority read-modify-write, video side reads and clears the display bank.
module line_buf_pp #(
  parameter int unsigned    AW      = 9,
  parameter int unsigned    DW      = 11,
  parameter int unsigned    TW      = 4,
  parameter bit             PRIO    = 1'b1,
  parameter logic [DW-1:0]  CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          swap,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_adr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_adr,
  output logic [DW-1:0] rd_dat,
  output logic          rd_vld,
  output logic          bank,
  output logic          coll,
  output logic          init_busy
);

  localparam int unsigned DEPTH = 2**AW;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          bank_q, bank_d;

  logic          s0_v_q, s0_v_d;
  logic [AW-1:0] s0_adr_q;
  logic [DW-1:0] s0_dat_q;
  logic          s0_bank_q;

  logic          s1_v_q;
  logic [AW-1:0] s1_adr_q;
  logic [DW-1:0] s1_dat_q;
  logic [DW-1:0] s1_ex_q, s1_ex_d;
  logic          s1_bank_q;

  logic [DW-1:0] rd_dat_q, rd_dat_d;
  logic          rd_vld_q;
  logic          coll_q, coll_d;

  logic [DW-1:0] mem_q [2][DEPTH];

  logic          run;
  logic          disp;
  logic          new_opq;
  logic          ex_opq;
  logic          s2_we;
  logic          fwd;

  always_comb begin
    run     = (state_q == S_RUN);
    disp    = ~bank_q;
    new_opq = |s1_dat_q[TW-1:0];
    ex_opq  = |s1_ex_q[TW-1:0];
    s2_we   = s1_v_q && new_opq && (PRIO ? !ex_opq : 1'b1);
    coll_d  = s1_v_q && new_opq && ex_opq;
    // Stage-2 write lands on the same edge as the stage-1 read; bypass memory.
    fwd     = s2_we && (s1_bank_q == s0_bank_q) && (s1_adr_q == s0_adr_q);
    s1_ex_d = fwd ? s1_dat_q : mem_q[s0_bank_q][s0_adr_q];
    s0_v_d  = run && wr_en;
    bank_d  = bank_q ^ (run && swap);

    rd_dat_d = rd_dat_q;
    if (rd_en) begin
      rd_dat_d = run ? mem_q[disp][rd_adr] : CLR_VAL;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == '1) begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      bank_q    <= 1'b0;
      s0_v_q    <= 1'b0;
      s0_adr_q  <= '0;
      s0_dat_q  <= '0;
      s0_bank_q <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_adr_q  <= '0;
      s1_dat_q  <= '0;
      s1_ex_q   <= '0;
      s1_bank_q <= 1'b0;
      rd_dat_q  <= CLR_VAL;
      rd_vld_q  <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      s0_v_q    <= s0_v_d;
      s0_adr_q  <= wr_adr;
      s0_dat_q  <= wr_dat;
      s0_bank_q <= bank_q;
      s1_v_q    <= s0_v_q;
      s1_adr_q  <= s0_adr_q;
      s1_dat_q  <= s0_dat_q;
      s1_ex_q   <= s1_ex_d;
      s1_bank_q <= s0_bank_q;
      rd_dat_q  <= rd_dat_d;
      rd_vld_q  <= rd_en;
      coll_q    <= coll_d;
    end
  end

  // Storage is not reset. A straggling pipeline write overrides a read-clear.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[0][cnt_q] <= CLR_VAL;
      mem_q[1][cnt_q] <= CLR_VAL;
    end else begin
      if (rd_en) begin
        mem_q[disp][rd_adr] <= CLR_VAL;
      end
      if (s2_we) begin
        mem_q[s1_bank_q][s1_adr_q] <= s1_dat_q;
      end
    end
  end

  assign rd_dat    = rd_dat_q;
  assign rd_vld    = rd_vld_q;
  assign bank      = bank_q;
  assign coll      = coll_q;
  assign init_busy = (state_q == S_INIT);

endmodule

// File: tb/tb_line_buf_pp.sv
// Bench for line_buf_pp: PRIO=0 and PRIO=1 instances share stimulus; reads are
// scored against a queue of expected {prio1, prio0} pixel pairs.
`timescale 1ns/1ps
module tb_line_buf_pp;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 11;

  typedef logic [1:0][DW-1:0] exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          swap = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_adr = '0;
  logic [DW-1:0] wr_dat = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_adr = '0;

  logic [1:0][DW-1:0] rdat;
  logic [1:0]         rvld, bnk, coll, busy;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  logic exp_bank = 1'b0;

  always #5 clk = ~clk;

  line_buf_pp #(.PRIO(1'b0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .swap(swap),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .rd_en(rd_en), .rd_adr(rd_adr),
    .rd_dat(rdat[0]), .rd_vld(rvld[0]), .bank(bnk[0]), .coll(coll[0]), .init_busy(busy[0])
  );

  line_buf_pp #(.PRIO(1'b1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .swap(swap),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .rd_en(rd_en), .rd_adr(rd_adr),
    .rd_dat(rdat[1]), .rd_vld(rvld[1]), .bank(bnk[1]), .coll(coll[1]), .init_busy(busy[1])
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_adr = a; wr_dat = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    cyc();
    swap = 1'b0;
    exp_bank = ~exp_bank;
  endtask

  task automatic rd(input logic [AW-1:0] a, input exp_t e);
    rd_en = 1'b1; rd_adr = a;
    sbq.push_back(e);
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    int   n;
    exp_t e;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({rvld, bnk, coll, busy} !== 8'b00_00_00_11) begin
      failures++;
      $display("FAIL reset_ctl: got vld/bank/coll/busy=%b want 00000011", {rvld, bnk, coll, busy});
    end
    checks++;
    if (rdat !== '0) begin
      failures++; $display("FAIL reset_rd_dat: got %h want 0", rdat);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) cyc();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 2'b11) begin
      failures++; $display("FAIL midsweep_busy: got %b want 11", busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (busy !== 2'b00 && n < 2000) begin
      if (n == 200) begin
        wr_en = 1'b1; wr_adr = AW'(3); wr_dat = 11'h0F5; swap = 1'b1;
        rd_en = 1'b1; rd_adr = AW'(7); sbq.push_back('0);
      end
      cyc();
      n++;
      if (n == 201) begin
        wr_en = 1'b0; swap = 1'b0; rd_en = 1'b0;
        checks++;
        if (bnk !== 2'b00) begin
          failures++; $display("FAIL init_swap_ignored: got bank %b want 00", bnk);
        end
        checks++;
        if (rvld !== 2'b11) begin
          failures++; $display("FAIL init_rd_vld: got %b want 11", rvld);
        end
        if (sbq.size() == 0) begin
          checks++; failures++; $display("FAIL init_rd_sb: got empty queue want entry");
        end else begin
          e = sbq.pop_front();
          for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdat[d] !== e[d]) begin
              failures++; $display("FAIL init_rd_dat prio%0d: got %h want %h", d, rdat[d], e[d]);
            end
          end
        end
      end
    end
    checks++;
    if (n != 512) begin
      failures++; $display("FAIL sweep_len: got %0d cycles want 512", n);
    end
    do_swap();
    rd(AW'(3), '0);
    checks++;
    if (rvld !== 2'b11) begin
      failures++; $display("FAIL init_wr_ignored_vld: got %b want 11", rvld);
    end
    if (sbq.size() == 0) begin
      checks++; failures++; $display("FAIL init_wr_ignored_sb: got empty queue want entry");
    end else begin
      e = sbq.pop_front();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rdat[d] !== e[d]) begin
          failures++; $display("FAIL init_wr_ignored prio%0d: got %h want %h", d, rdat[d], e[d]);
        end
      end
    end
    do_swap();
  endtask

  task automatic test_sweep_clear();
    int   n;
    exp_t e;
    for (int a = 0; a < 512; a++) wr(AW'(a), DW'(a * 7) | DW'(1));
    repeat (3) cyc();
    do_swap();
    for (int a = 0; a < 512; a++) wr(AW'(a), DW'(a ^ 'h35A) | DW'(1));
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    exp_bank = 1'b0;
    sbq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (busy !== 2'b00 && n < 2000) begin
      cyc();
      n++;
    end
    checks++;
    if (n != 512) begin
      failures++; $display("FAIL sweep_len2: got %0d cycles want 512", n);
    end
    for (int pass = 0; pass < 2; pass++) begin
      do_swap();
      for (int a = 0; a < 512; a++) begin
        rd(AW'(a), '0);
        checks++;
        if (rvld !== 2'b11) begin
          failures++; $display("FAIL sweep_rd_vld adr %0d: got %b want 11", a, rvld);
        end
        if (sbq.size() == 0) begin
          checks++; failures++; $display("FAIL sweep_sb adr %0d: got empty queue want entry", a);
        end else begin
          e = sbq.pop_front();
          for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdat[d] !== e[d]) begin
              failures++; $display("FAIL sweep_clear prio%0d adr %0d: got %h want %h", d, a, rdat[d], e[d]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_prio();
    int   c0 = 0, c1 = 0;
    exp_t e;
    wr(AW'(10), 11'h123);
    wr(AW'(10), 11'h456);
    repeat (6) begin cyc(); c0 += int'(coll[0]); c1 += int'(coll[1]); end
    checks++;
    if (c0 != 1 || c1 != 1) begin
      failures++; $display("FAIL prio_coll: got pulses p0=%0d p1=%0d want 1 1", c0, c1);
    end
    do_swap();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) rd(AW'(10), {11'h123, 11'h456});
      else        rd(AW'(10), '0);
      checks++;
      if (rvld !== 2'b11) begin
        failures++; $display("FAIL prio_rd_vld %0d: got %b want 11", k, rvld);
      end
      if (sbq.size() == 0) begin
        checks++; failures++; $display("FAIL prio_sb %0d: got empty queue want entry", k);
      end else begin
        e = sbq.pop_front();
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (rdat[d] !== e[d]) begin
            failures++; $display("FAIL prio_rd%0d prio%0d: got %h want %h", k, d, rdat[d], e[d]);
          end
        end
      end
    end
  endtask

  task automatic test_transparency();
    int   c0 = 0, c1 = 0;
    exp_t e;
    wr(AW'(5), 11'h7F0);
    repeat (6) begin cyc(); c0 += int'(coll[0]); c1 += int'(coll[1]); end
    checks++;
    if (c0 != 0 || c1 != 0) begin
      failures++; $display("FAIL transp_coll: got pulses p0=%0d p1=%0d want 0 0", c0, c1);
    end
    do_swap();
    rd(AW'(5), '0);
    checks++;
    if (rvld !== 2'b11) begin
      failures++; $display("FAIL transp_rd_vld: got %b want 11", rvld);
    end
    if (sbq.size() == 0) begin
      checks++; failures++; $display("FAIL transp_sb: got empty queue want entry");
    end else begin
      e = sbq.pop_front();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rdat[d] !== e[d]) begin
          failures++; $display("FAIL transp_rd prio%0d: got %h want %h", d, rdat[d], e[d]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   c0 = 0, c1 = 0;
    exp_t e;
    wr(AW'(30), 11'h101);
    wr(AW'(30), 11'h202);
    repeat (6) begin cyc(); c0 += int'(coll[0]); c1 += int'(coll[1]); end
    checks++;
    if (c0 != 1 || c1 != 1) begin
      failures++; $display("FAIL b2b_coll: got pulses p0=%0d p1=%0d want 1 1", c0, c1);
    end
    do_swap();
    rd(AW'(30), {11'h101, 11'h202});
    checks++;
    if (rvld !== 2'b11) begin
      failures++; $display("FAIL b2b_rd_vld: got %b want 11", rvld);
    end
    if (sbq.size() == 0) begin
      checks++; failures++; $display("FAIL b2b_sb: got empty queue want entry");
    end else begin
      e = sbq.pop_front();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rdat[d] !== e[d]) begin
          failures++; $display("FAIL b2b_rd prio%0d: got %h want %h", d, rdat[d], e[d]);
        end
      end
    end
  endtask

  task automatic test_swap_pipeline();
    exp_t e;
    if (exp_bank) do_swap();
    checks++;
    if (bnk !== 2'b00) begin
      failures++; $display("FAIL swap_pre_bank: got %b want 00", bnk);
    end
    wr_en = 1'b1; wr_adr = AW'(20); wr_dat = 11'h0A1; swap = 1'b1;
    cyc();
    wr_en = 1'b0; swap = 1'b0; exp_bank = 1'b1;
    checks++;
    if (bnk !== 2'b11) begin
      failures++; $display("FAIL swap_post_bank: got %b want 11", bnk);
    end
    repeat (4) cyc();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) rd(AW'(20), {11'h0A1, 11'h0A1});
      else begin do_swap(); rd(AW'(20), '0); end
      checks++;
      if (rvld !== 2'b11) begin
        failures++; $display("FAIL swap_rd_vld %0d: got %b want 11", k, rvld);
      end
      if (sbq.size() == 0) begin
        checks++; failures++; $display("FAIL swap_sb %0d: got empty queue want entry", k);
      end else begin
        e = sbq.pop_front();
        for (int d = 0; d < 2; d++) begin
          checks++;
          if (rdat[d] !== e[d]) begin
            failures++; $display("FAIL swap_rd%0d prio%0d: got %h want %h", k, d, rdat[d], e[d]);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int   n;
    exp_t e;
    wr(AW'(40), 11'h3C7);
    repeat (3) cyc();
    if (!exp_bank) do_swap();
    rd(AW'(40), {11'h3C7, 11'h3C7});
    checks++;
    if (rvld !== 2'b11) begin
      failures++; $display("FAIL ar_rd_vld: got %b want 11", rvld);
    end
    if (sbq.size() == 0) begin
      checks++; failures++; $display("FAIL ar_sb: got empty queue want entry");
    end else begin
      e = sbq.pop_front();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rdat[d] !== e[d]) begin
          failures++; $display("FAIL ar_rd prio%0d: got %h want %h", d, rdat[d], e[d]);
        end
      end
    end
    #2 rst_n = 1'b0;
    exp_bank = 1'b0;
    #1;
    checks++;
    if ({rvld, bnk, coll, busy} !== 8'b00_00_00_11) begin
      failures++;
      $display("FAIL ar_ctl: got vld/bank/coll/busy=%b want 00000011", {rvld, bnk, coll, busy});
    end
    checks++;
    if (rdat !== '0) begin
      failures++; $display("FAIL ar_rd_dat: got %h want 0", rdat);
    end
    #2 rst_n = 1'b1;
    n = 0;
    while (busy !== 2'b00 && n < 2000) begin
      cyc();
      n++;
    end
    checks++;
    if (n != 512) begin
      failures++; $display("FAIL ar_sweep_len: got %0d cycles want 512", n);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep_clear();
    test_prio();
    test_transparency();
    test_back_to_back();
    test_swap_pipeline();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
